// File: rtl/shortcut_scheduler.sv
// shortcut_scheduler
// Walks a stored feature map in channel / row / column-group order. It issues
// reads to the activation buffer and streams tagged pixel groups into the
// shortcut block. A credit-controlled skid FIFO absorbs the buffer read latency
// and downstream back-pressure. Beats returned by the shortcut block are counted,
// and done is raised once the whole map has drained.
// Optional build macro: SHORTCUT_SCHED_PERF_EN adds the 32-bit stall_cycles port.

module shortcut_scheduler_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNTW       = 3
) (
    input logic            clk,
    input logic            rst,
    input logic            push,
    input logic            pop,
    input logic [CNTW-1:0] count
);
    // A return may only land on a full FIFO when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && (count == CNTW'(FIFO_DEPTH))))
        else $error("shortcut_scheduler: skid FIFO overflow");
endmodule

module shortcut_scheduler #(
    parameter int N                = 16,
    parameter int IN_CHANNELS      = 24,
    parameter int FEATURE_SIZE     = 28,
    parameter int SPATIAL_PARALLEL = 2,
    parameter int RD_LATENCY       = 2,
    parameter int FIFO_DEPTH       = 4,
    localparam int AW = $clog2(IN_CHANNELS*FEATURE_SIZE*FEATURE_SIZE),
    localparam int CW = $clog2(IN_CHANNELS),
    localparam int PW = $clog2(FEATURE_SIZE),
    localparam int DW = SPATIAL_PARALLEL*N
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [AW-1:0]                rd_addr,
    input  logic [DW-1:0]                rd_data,
    output logic [DW-1:0]                data_out,
    output logic [SPATIAL_PARALLEL*CW-1:0] channel_out,
    output logic [SPATIAL_PARALLEL-1:0]  valid_out,
    input  logic                         ready_in,
    output logic [PW-1:0]                row_idx,
    output logic [PW-1:0]                col_idx,
    input  logic [SPATIAL_PARALLEL-1:0]  sc_valid
`ifdef SHORTCUT_SCHED_PERF_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);
    localparam int TOTAL = IN_CHANNELS*FEATURE_SIZE*FEATURE_SIZE/SPATIAL_PARALLEL;
    localparam int OCW   = $clog2(TOTAL+1);
    localparam int PTRW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW  = $clog2(FIFO_DEPTH+1);
    localparam int OW    = $clog2(FIFO_DEPTH+RD_LATENCY+3);
    localparam int EW    = DW + CW + 2*PW;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t          r_state, w_next;
    logic            r_busy, r_done, r_rd_en;
    logic [AW-1:0]   r_rd_addr, r_next_addr;
    logic [CW-1:0]   r_c, r_iss_c;
    logic [PW-1:0]   r_r, r_j, r_iss_r, r_iss_j;
    logic [OCW-1:0]  r_out_count;

    logic [RD_LATENCY-1:0] r_pv;
    logic [CW-1:0]   r_pc [RD_LATENCY];
    logic [PW-1:0]   r_pr [RD_LATENCY];
    logic [PW-1:0]   r_pj [RD_LATENCY];

    logic [EW-1:0]   r_mem [FIFO_DEPTH];
    logic [PTRW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNTW-1:0] r_count;

    logic            w_issue, w_start_acc, w_last_group, w_has_credit;
    logic            w_push, w_pop;
    logic [OW-1:0]   w_inflight, w_used, w_limit;
    logic [EW-1:0]   w_head;
    logic [CW-1:0]   w_head_c;

    assign w_start_acc  = (r_state == ST_IDLE) && start;
    assign w_last_group = (r_c == CW'(IN_CHANNELS-1)) && (r_r == PW'(FEATURE_SIZE-1))
                          && (r_j == PW'(FEATURE_SIZE-SPATIAL_PARALLEL));
    assign w_push       = r_pv[RD_LATENCY-1];
    assign w_pop        = (r_count != {CNTW{1'b0}}) && ready_in;

    // Count reads already committed but not yet sitting in the FIFO.
    always_comb begin
        w_inflight = OW'(r_rd_en);
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + OW'(r_pv[i]);
        end
    end

    // A slot popped at this edge is free again long before any new read can return.
    assign w_used       = OW'(r_count) + w_inflight;
    assign w_limit      = OW'(FIFO_DEPTH) + OW'(w_pop);
    assign w_has_credit = (w_used < w_limit);

    // Next-state and read-issue decision.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_ISSUE;
                else       w_next = ST_IDLE;
            end
            ST_ISSUE: begin
                if (w_has_credit) begin
                    w_issue = 1'b1;
                    if (w_last_group) w_next = ST_DRAIN;
                    else              w_next = ST_ISSUE;
                end else begin
                    w_next = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if ((r_count == {CNTW{1'b0}}) && (w_inflight == {OW{1'b0}})
                    && (r_out_count == OCW'(TOTAL))) w_next = ST_DONE;
                else                                 w_next = ST_DRAIN;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register, status flags, read port and map walk counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= {AW{1'b0}};
            r_next_addr <= {AW{1'b0}};
            r_c         <= {CW{1'b0}};
            r_r         <= {PW{1'b0}};
            r_j         <= {PW{1'b0}};
            r_iss_c     <= {CW{1'b0}};
            r_iss_r     <= {PW{1'b0}};
            r_iss_j     <= {PW{1'b0}};
            r_out_count <= {OCW{1'b0}};
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_ISSUE) || (w_next == ST_DRAIN);
            r_done  <= (w_next == ST_DONE);
            r_rd_en <= w_issue;
            if (w_start_acc) begin
                r_c         <= {CW{1'b0}};
                r_r         <= {PW{1'b0}};
                r_j         <= {PW{1'b0}};
                r_next_addr <= {AW{1'b0}};
            end else if (w_issue) begin
                r_rd_addr   <= r_next_addr;
                r_iss_c     <= r_c;
                r_iss_r     <= r_r;
                r_iss_j     <= r_j;
                r_next_addr <= r_next_addr + AW'(SPATIAL_PARALLEL);
                if (r_j == PW'(FEATURE_SIZE-SPATIAL_PARALLEL)) begin
                    r_j <= {PW{1'b0}};
                    if (r_r == PW'(FEATURE_SIZE-1)) begin
                        r_r <= {PW{1'b0}};
                        r_c <= w_last_group ? {CW{1'b0}} : r_c + CW'(1);
                    end else begin
                        r_r <= r_r + PW'(1);
                    end
                end else begin
                    r_j <= r_j + PW'(SPATIAL_PARALLEL);
                end
            end
            if (w_start_acc) begin
                r_out_count <= {OCW{1'b0}};
            end else if ((|sc_valid) && (r_out_count != OCW'(TOTAL))) begin
                r_out_count <= r_out_count + OCW'(1);
            end
        end
    end

    // Tag pipeline: follows each read until its data returns from the buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pv <= {RD_LATENCY{1'b0}};
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pc[i] <= {CW{1'b0}};
                r_pr[i] <= {PW{1'b0}};
                r_pj[i] <= {PW{1'b0}};
            end
        end else begin
            r_pv[0] <= r_rd_en;
            r_pc[0] <= r_iss_c;
            r_pr[0] <= r_iss_r;
            r_pj[0] <= r_iss_j;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pc[i] <= r_pc[i-1];
                r_pr[i] <= r_pr[i-1];
                r_pj[i] <= r_pj[i-1];
            end
        end
    end

    // Skid FIFO holding returned data together with its tags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= {PTRW{1'b0}};
            r_rd_ptr <= {PTRW{1'b0}};
            r_count  <= {CNTW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {EW{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {rd_data, r_pc[RD_LATENCY-1], r_pr[RD_LATENCY-1],
                                    r_pj[RD_LATENCY-1]};
                r_wr_ptr <= (r_wr_ptr == PTRW'(FIFO_DEPTH-1)) ? {PTRW{1'b0}}
                                                               : r_wr_ptr + PTRW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTRW'(FIFO_DEPTH-1)) ? {PTRW{1'b0}}
                                                               : r_rd_ptr + PTRW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_c    = w_head[2*PW +: CW];
    assign data_out    = w_head[EW-1 -: DW];
    assign channel_out = {SPATIAL_PARALLEL{w_head_c}};
    assign row_idx     = w_head[PW +: PW];
    assign col_idx     = w_head[0 +: PW];
    assign valid_out   = {SPATIAL_PARALLEL{r_count != {CNTW{1'b0}}}};
    assign busy        = r_busy;
    assign done        = r_done;
    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;

`ifdef SHORTCUT_SCHED_PERF_EN
    logic [31:0] r_stall_cycles;
    logic        w_stall;

    assign w_stall = ((r_count != {CNTW{1'b0}}) && !ready_in)
                     || ((r_state == ST_ISSUE) && !w_has_credit);

    // Stall counter: cleared on start, frozen once the run finishes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= 32'd0;
        end else if (w_start_acc) begin
            r_stall_cycles <= 32'd0;
        end else if (w_stall) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    shortcut_scheduler_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNTW       (CNTW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .count (r_count)
    );
endmodule

// File: tb/tb_shortcut_scheduler.sv
// Scoreboard bench for shortcut_scheduler: a reference model expands every run into
// the expected read addresses and tagged beats, and monitors compare DUT traffic.
module tb_shortcut_scheduler;
    localparam int N = 16, IC = 24, FS = 28, SP = 2, RDL = 2, FD = 4;
    localparam int AW = $clog2(IC*FS*FS), CW = $clog2(IC), PW = $clog2(FS);
    localparam int DW = SP*N, TOTAL = IC*FS*FS/SP;

    typedef struct {int addr; int c; int r; int j;} beat_t;

    logic clk, rst, start, busy, done, rd_en, ready_in;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data, data_out;
    logic [SP*CW-1:0] channel_out;
    logic [SP-1:0]    valid_out, sc_valid;
    logic [PW-1:0]    row_idx, col_idx;
`ifdef SHORTCUT_SCHED_PERF_EN
    logic [31:0]      stall_cycles;
`endif

    shortcut_scheduler #(.N(N), .IN_CHANNELS(IC), .FEATURE_SIZE(FS),
        .SPATIAL_PARALLEL(SP), .RD_LATENCY(RDL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out),
        .channel_out(channel_out), .valid_out(valid_out), .ready_in(ready_in),
        .row_idx(row_idx), .col_idx(col_idx), .sc_valid(sc_valid)
`ifdef SHORTCUT_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int addr_q[$];
    beat_t exp_q[$];
    int rd_cnt, acc_cnt, max_out, last_addr, stall_model, done_cnt;
    int mode;                 // 0: ready high, 1: random ready, 2: ready low
    bit prev_hold;
    logic [63:0] prev_snap;

    function automatic void chk(input bit ok, input string nm,
                                input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    // Buffer contents: every word address holds a scrambled version of itself.
    function automatic logic [DW-1:0] group_at(input int a);
        logic [DW-1:0] g;
        logic [31:0] h;
        g = {DW{1'b0}};
        for (int k = 0; k < SP; k++) begin
            h = (32'(a + k) * 32'd40503) ^ 32'h00005A5A;
            g[k*N +: N] = h[N-1:0];
        end
        return g;
    endfunction

    // Buffer model with fixed read latency.
    logic [RDL-1:0] tb_pv;
    int tb_pa [RDL];
    always @(posedge clk) begin
        tb_pv[0] <= rd_en;
        tb_pa[0] <= int'(rd_addr);
        for (int i = 1; i < RDL; i++) begin
            tb_pv[i] <= tb_pv[i-1];
            tb_pa[i] <= tb_pa[i-1];
        end
    end
    assign rd_data = tb_pv[RDL-1] ? group_at(tb_pa[RDL-1]) : {DW{1'b1}};

    // Shortcut block model: echoes each accepted beat 10 cycles later.
    logic [9:0] sc_pipe;
    always @(posedge clk) begin
        if (!rst) sc_pipe <= 10'd0;
        else      sc_pipe <= {sc_pipe[8:0], (valid_out != {SP{1'b0}}) && ready_in};
    end
    assign sc_valid = {SP{sc_pipe[9]}};

    // Ready driver.
    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       ready_in = 1'b1;
                1:       ready_in = ($urandom_range(0, 3) != 0);
                default: ready_in = 1'b0;
            endcase
        end
    end

    // Monitor: read addresses, delivered beats, hold stability, done.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                logic [63:0] snap;
                snap = 64'({valid_out, data_out, channel_out, row_idx, col_idx});
                if (prev_hold) chk(snap == prev_snap, "hold_stable", snap, prev_snap);
                prev_hold = (valid_out != {SP{1'b0}}) && !ready_in;
                prev_snap = snap;
                if (prev_hold) stall_model++;
                if (rd_en) begin
                    if (addr_q.size() == 0) begin
                        chk(1'b0, "rd_extra", 64'(rd_addr), 64'(0));
                    end else begin
                        int ea;
                        ea = addr_q.pop_front();
                        chk(int'(rd_addr) == ea, "rd_addr", 64'(rd_addr), 64'(ea));
                    end
                    if (rd_cnt == 0)   chk(rd_addr == AW'(0), "first_addr", 64'(rd_addr), 64'(0));
                    if (rd_cnt == 392) chk(rd_addr == AW'(784), "boundary_addr", 64'(rd_addr), 64'(784));
                    rd_cnt++;
                    last_addr = int'(rd_addr);
                end
                if (rd_cnt - acc_cnt > max_out) max_out = rd_cnt - acc_cnt;
                if ((valid_out != {SP{1'b0}}) && ready_in) begin
                    chk(valid_out == {SP{1'b1}}, "valid_lanes", 64'(valid_out), 64'(3));
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "beat_extra", 64'(data_out), 64'(0));
                    end else begin
                        beat_t e;
                        logic [SP*CW-1:0] ech;
                        logic [63:0] et, at;
                        e = exp_q.pop_front();
                        for (int k = 0; k < SP; k++) ech[k*CW +: CW] = CW'(e.c);
                        et = 64'({ech, PW'(e.r), PW'(e.j)});
                        at = 64'({channel_out, row_idx, col_idx});
                        chk(data_out == group_at(e.addr), "beat_data", 64'(data_out),
                            64'(group_at(e.addr)));
                        chk(at == et, "beat_tags", at, et);
                        if (e.c == 1 && e.r == 0 && e.j == 0)
                            chk(channel_out == {SP{CW'(1)}}, "boundary_chan",
                                64'(channel_out), 64'({SP{CW'(1)}}));
                    end
                    acc_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    chk(busy == 1'b0, "busy_at_done", 64'(busy), 64'(0));
                    chk(exp_q.size() == 0, "drained_at_done", 64'(exp_q.size()), 64'(0));
                end
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic clear_model();
        addr_q.delete();
        exp_q.delete();
        rd_cnt = 0; acc_cnt = 0; max_out = 0; stall_model = 0; last_addr = -1;
        prev_hold = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        clear_model();
        for (int c = 0; c < IC; c++)
            for (int r = 0; r < FS; r++)
                for (int j = 0; j < FS; j += SP) begin
                    beat_t b;
                    b.addr = c*FS*FS + r*FS + j; b.c = c; b.r = r; b.j = j;
                    addr_q.push_back(b.addr);
                    exp_q.push_back(b);
                end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk(busy == 1'b1, "busy_after_start", 64'(busy), 64'(1));
    endtask

    task automatic check_zero();
        chk({busy, done, rd_en, valid_out, rd_addr} == '0, "reset_ctrl",
            64'({busy, done, rd_en, valid_out, rd_addr}), 64'(0));
        chk({data_out, channel_out, row_idx, col_idx} == '0, "reset_data",
            64'({data_out, channel_out, row_idx, col_idx}), 64'(0));
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        chk(done_cnt == d0 + 1, "done_seen", 64'(done_cnt), 64'(d0 + 1));
    endtask

    task automatic run_end_checks();
        chk(rd_cnt == TOTAL, "rd_count", 64'(rd_cnt), 64'(TOTAL));
        chk(acc_cnt == TOTAL, "beat_count", 64'(acc_cnt), 64'(TOTAL));
        chk(last_addr == 18814, "last_addr", 64'(last_addr), 64'(18814));
        chk(max_out <= FD, "max_outstanding", 64'(max_out), 64'(FD));
    endtask

    initial begin
        int d_before;
        mode = 0; rst = 1'b0; start = 1'b0;
        done_cnt = 0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #1 rst = 1'b1;

        // Run 1: ready mostly high, stray start, two back-pressure windows.
        do_start();
        repeat (100) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2900) @(posedge clk);
        mode = 2;
        repeat (20) @(posedge clk);
        mode = 0;
        repeat (3000) @(posedge clk);
        mode = 2;
        repeat (7) @(posedge clk);
        mode = 0;
        wait_done(30000);
        run_end_checks();
`ifdef SHORTCUT_SCHED_PERF_EN
        chk(stall_cycles >= 32'(stall_model), "stall_cycles", 64'(stall_cycles), 64'(stall_model));
        chk(stall_cycles >= 32'd7, "stall_min", 64'(stall_cycles), 64'(7));
`endif
        repeat (50) @(posedge clk);
        chk(done_cnt == 1, "single_done", 64'(done_cnt), 64'(1));

        // Run 2: random ready, aborted by reset, then a full restart.
        do_start();
        mode = 1;
        repeat (500) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        clear_model();
        @(negedge clk);
        check_zero();
        d_before = done_cnt;
        repeat (30) @(posedge clk);
        chk(done_cnt == d_before, "no_spurious_done", 64'(done_cnt), 64'(d_before));
        do_start();
        wait_done(40000);
        run_end_checks();
        mode = 0;
        repeat (50) @(posedge clk);
        chk(done_cnt == d_before + 1, "single_done_2", 64'(done_cnt), 64'(d_before + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
